vrf_wr_arbiter: RTL and testbench



---
 rtl/vrf_wr_arbiter_if.sv | 33 +++
 rtl/vrf_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_vrf_wr_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vrf_wr_arbiter_if.sv
// Requester-side handshake bus and register-file write-port bus of the
// vector register file write arbiter. The arbiter uses the slave modport;
// the requester/register-file environment uses the master modport.
interface vrf_wr_arbiter_if #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_WR_PORTS = 4,
  parameter int NUM_REG      = 32,
  parameter int DATA_SIZE    = 2048
);
  localparam int ADDRESS = $clog2(NUM_REG);
  localparam int STRB_W  = DATA_SIZE / 8;

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0][ADDRESS-1:0]      req_addr;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0]    req_data;
  logic [NUM_REQ-1:0][STRB_W-1:0]       req_strb;
  logic [NUM_REQ-1:0]                   req_ready;

  logic [NUM_WR_PORTS-1:0]              wr_en;
  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0] wr_addr;
  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0] wr_data;
  logic [NUM_WR_PORTS-1:0][STRB_W-1:0]  wr_strb;

  modport master (
    output req_valid, req_addr, req_data, req_strb,
    input  req_ready, wr_en, wr_addr, wr_data, wr_strb
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_strb,
    output req_ready, wr_en, wr_addr, wr_data, wr_strb
  );
endinterface

// File: rtl/vrf_wr_arbiter.sv
// Vector register file write arbiter: shares NUM_WR_PORTS write ports among
// NUM_REQ requesters, round-robin, never granting two requests to the same
// register in one cycle. Write ports are driven from registers loaded on the
// edge after the handshake.
// Optional build macro VRF_ARB_PERF_CNT_EN adds saturating 32-bit handshake
// and address-conflict counters (grant_cnt, conflict_cnt).
module vrf_wr_arbiter #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_WR_PORTS = 4,
  parameter int NUM_REG      = 32,
  parameter int DATA_SIZE    = 2048
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  vrf_wr_arbiter_if.slave bus
`ifdef VRF_ARB_PERF_CNT_EN
  ,
  output logic [31:0] grant_cnt,
  output logic [31:0] conflict_cnt
`endif
);
  localparam int ADDRESS = $clog2(NUM_REG);
  localparam int STRB_W  = DATA_SIZE / 8;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                        grant_s;
  logic [NUM_WR_PORTS-1:0]                   port_vld_s;
  logic [NUM_WR_PORTS-1:0][PTR_W-1:0]        port_src_s;
  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]      port_addr_s;
  logic [PTR_W:0]                            sum_s;
  logic [PTR_W-1:0]                          idx_s;
  logic                                      hit_s, elig_s, take_s;
  int                                        n_grant_s, n_conf_s;

  logic [NUM_WR_PORTS-1:0]                   wr_en_q, wr_en_d;
  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]      wr_addr_q, wr_addr_d;
  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0]    wr_data_q, wr_data_d;
  logic [NUM_WR_PORTS-1:0][STRB_W-1:0]       wr_strb_q, wr_strb_d;

  // Round-robin scan from rr_ptr: grant valid requesters until ports run out,
  // skipping (not blocking on) any whose address is already granted this cycle.
  always_comb begin
    grant_s     = '0;
    port_vld_s  = '0;
    port_src_s  = '0;
    port_addr_s = '0;
    rr_ptr_d    = rr_ptr_q;
    n_grant_s   = 0;
    n_conf_s    = 0;
    sum_s       = '0;
    idx_s       = '0;
    hit_s       = 1'b0;
    elig_s      = 1'b0;
    take_s      = 1'b0;
    for (int s = 0; s < NUM_REQ; s++) begin
      sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(s);
      sum_s = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
      idx_s = sum_s[PTR_W-1:0];
      hit_s = 1'b0;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        hit_s = hit_s | ((k < n_grant_s) && (port_addr_s[k] == bus.req_addr[idx_s]));
      end
      elig_s = !rst && !stall && bus.req_valid[idx_s] && (n_grant_s < NUM_WR_PORTS);
      take_s = elig_s && !hit_s;
      grant_s[idx_s] = grant_s[idx_s] | take_s;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        port_vld_s[k]  = port_vld_s[k] | (take_s && (k == n_grant_s));
        port_src_s[k]  = (take_s && (k == n_grant_s)) ? idx_s : port_src_s[k];
        port_addr_s[k] = (take_s && (k == n_grant_s)) ? bus.req_addr[idx_s] : port_addr_s[k];
      end
      rr_ptr_d  = take_s ? ((idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (idx_s + PTR_W'(1))) : rr_ptr_d;
      n_grant_s = n_grant_s + int'(take_s);
      n_conf_s  = n_conf_s + int'(elig_s && hit_s);
    end
  end

  // Next values of the port registers: granted ports copy their requester,
  // unused ports keep their previous address/data/strobes.
  always_comb begin
    wr_en_d   = port_vld_s;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      wr_addr_d[k] = port_vld_s[k] ? bus.req_addr[port_src_s[k]] : wr_addr_q[k];
      wr_data_d[k] = port_vld_s[k] ? bus.req_data[port_src_s[k]] : wr_data_q[k];
      wr_strb_d[k] = port_vld_s[k] ? bus.req_strb[port_src_s[k]] : wr_strb_q[k];
    end
  end

  // Port registers and round-robin pointer; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_strb   = wr_strb_q;

`ifdef VRF_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [32:0] gsum_s, csum_s;

  // Add this cycle's handshake and conflict-skip counts, saturating at all ones.
  always_comb begin
    gsum_s         = {1'b0, grant_cnt_q} + 33'(n_grant_s);
    csum_s         = {1'b0, conflict_cnt_q} + 33'(n_conf_s);
    grant_cnt_d    = gsum_s[32] ? 32'hFFFF_FFFF : gsum_s[31:0];
    conflict_cnt_d = csum_s[32] ? 32'hFFFF_FFFF : csum_s[31:0];
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q    <= 32'h0000_0000;
      conflict_cnt_q <= 32'h0000_0000;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt    = grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Self-checking bench for vrf_wr_arbiter: a table of per-cycle vectors with
// expected grants and port mapping, plus hand-written passthrough and
// (with VRF_ARB_PERF_CNT_EN) counter sequences. Expected port writes are
// queued when the grant is checked and compared one clock later.
module tb_vrf_wr_arbiter;
  localparam int NR = 8;
  localparam int NP = 4;
  localparam int NREG = 32;
  localparam int DW = 2048;
  localparam int SW = DW / 8;
  localparam int AW = 5;
  localparam int NV = 18;

  typedef logic [NR-1:0][AW-1:0] addr_vec_t;
  typedef logic [NR-1:0][DW-1:0] data_vec_t;
  typedef logic [NR-1:0][SW-1:0] strb_vec_t;

  typedef struct packed {
    logic             rst;
    logic             stall;
    logic             zstrb;
    logic [NR-1:0]    valid;
    addr_vec_t        addr;
    logic [NR-1:0]    exp_rdy;
    logic [NP-1:0][3:0] src;   // requester per port, 4'hF = port unused
  } vec_t;

  typedef struct packed {
    logic [NP-1:0]          en;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0][DW-1:0]  data;
    logic [NP-1:0][SW-1:0]  strb;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  int checks = 0;
  int failures = 0;
  wr_exp_t sb_q[$];
  wr_exp_t hold_e;
  vec_t tbl[NV];

  vrf_wr_arbiter_if #(.NUM_REQ(NR), .NUM_WR_PORTS(NP), .NUM_REG(NREG), .DATA_SIZE(DW)) bus();

`ifdef VRF_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt;
  logic [31:0] conflict_cnt;
`endif

  vrf_wr_arbiter #(.NUM_REQ(NR), .NUM_WR_PORTS(NP), .NUM_REG(NREG), .DATA_SIZE(DW)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .bus(bus)
`ifdef VRF_ARB_PERF_CNT_EN
    ,
    .grant_cnt(grant_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic addr_vec_t mk_addr(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    addr_vec_t r;
    r[0] = AW'(a0); r[1] = AW'(a1); r[2] = AW'(a2); r[3] = AW'(a3);
    r[4] = AW'(a4); r[5] = AW'(a5); r[6] = AW'(a6); r[7] = AW'(a7);
    return r;
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic z, input logic [NR-1:0] v,
                               input addr_vec_t a, input logic [NR-1:0] rdy, input logic [15:0] src);
    vec_t t;
    t.rst = r; t.stall = s; t.zstrb = z; t.valid = v; t.addr = a; t.exp_rdy = rdy; t.src = src;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, check grants, queue expected writes, check ports after the edge.
  task automatic apply(input logic r, input logic s, input logic [NR-1:0] v, input addr_vec_t a,
                       input data_vec_t d, input strb_vec_t sb, input logic [NR-1:0] exp_rdy,
                       input logic [NP-1:0][3:0] src, input string tag);
    wr_exp_t e;
    rst = r;
    stall = s;
    bus.req_valid = v;
    bus.req_addr = a;
    bus.req_data = d;
    bus.req_strb = sb;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    hold_e.en = '0;
    if (r) begin
      hold_e = '0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (src[k] != 4'hF) begin
          hold_e.en[k] = 1'b1;
          hold_e.addr[k] = a[src[k][2:0]];
          hold_e.data[k] = d[src[k][2:0]];
          hold_e.strb[k] = sb[src[k][2:0]];
        end
      end
    end
    sb_q.push_back(hold_e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " wr_en"}, 32'(bus.wr_en), 32'(e.en));
      for (int k = 0; k < NP; k++) begin
        chk($sformatf("%s wr_addr[%0d]", tag, k), 32'(bus.wr_addr[k]), 32'(e.addr[k]));
        checks++;
        if (bus.wr_data[k] !== e.data[k]) begin
          failures++;
          $display("FAIL %s wr_data[%0d]: got low word %0h expected low word %0h",
                   tag, k, bus.wr_data[k][31:0], e.data[k][31:0]);
        end
        checks++;
        if (bus.wr_strb[k] !== e.strb[k]) begin
          failures++;
          $display("FAIL %s wr_strb[%0d]: got low word %0h expected low word %0h",
                   tag, k, bus.wr_strb[k][31:0], e.strb[k][31:0]);
        end
      end
    end
  endtask

  initial begin
    data_vec_t d;
    strb_vec_t sb;
    addr_vec_t a18, a07, acf, a10, a9, a4, apt;
    a18 = mk_addr(1, 2, 3, 4, 5, 6, 7, 8);
    a07 = mk_addr(0, 1, 2, 3, 4, 5, 6, 7);
    acf = mk_addr(5, 5, 6, 0, 0, 0, 0, 0);
    a10 = mk_addr(10, 11, 12, 13, 14, 15, 16, 17);
    a9  = mk_addr(9, 9, 9, 9, 9, 3, 9, 9);
    a4  = mk_addr(4, 0, 0, 0, 0, 0, 0, 0);
    apt = mk_addr(0, 0, 0, 31, 0, 0, 0, 0);

    //           rst   stall zstrb valid  addr  ready  ports 3..0
    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 8'hFF, a18, 8'h00, 16'hFFFF);
    tbl[1]  = mkv(1'b1, 1'b0, 1'b0, 8'hFF, a18, 8'h00, 16'hFFFF);
    tbl[2]  = mkv(1'b0, 1'b0, 1'b0, 8'hFF, a18, 8'h0F, 16'h3210);
    tbl[3]  = mkv(1'b0, 1'b0, 1'b0, 8'hF0, a18, 8'hF0, 16'h7654);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 8'hFF, a07, 8'h0F, 16'h3210);
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, 8'hF0, a07, 8'hF0, 16'h7654);
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, 8'h07, acf, 8'h05, 16'hFF20);
    tbl[7]  = mkv(1'b0, 1'b0, 1'b0, 8'h02, acf, 8'h02, 16'hFFF1);
    tbl[8]  = mkv(1'b0, 1'b1, 1'b0, 8'hFF, a10, 8'h00, 16'hFFFF);
    tbl[9]  = mkv(1'b0, 1'b1, 1'b0, 8'hFF, a10, 8'h00, 16'hFFFF);
    tbl[10] = mkv(1'b0, 1'b1, 1'b0, 8'hFF, a10, 8'h00, 16'hFFFF);
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, 8'hFF, a10, 8'h3C, 16'h5432);
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, 8'hC3, a10, 8'hC3, 16'h1076);
    tbl[13] = mkv(1'b0, 1'b0, 1'b0, 8'hFF, a9,  8'h24, 16'hFF52);
    tbl[14] = mkv(1'b0, 1'b0, 1'b1, 8'hDB, a9,  8'h40, 16'hFFF6);
    tbl[15] = mkv(1'b0, 1'b0, 1'b0, 8'h01, a4,  8'h01, 16'hFFF0);
    tbl[16] = mkv(1'b1, 1'b0, 1'b0, 8'hFF, a18, 8'h00, 16'hFFFF);
    tbl[17] = mkv(1'b0, 1'b0, 1'b0, 8'hFF, a18, 8'h0F, 16'h3210);

    rst = 1'b1;
    stall = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_strb = '0;
    hold_e = '0;
    @(posedge clk);
    #1;

    for (int n = 0; n < NV; n++) begin
      for (int i = 0; i < NR; i++) begin
        d[i] = {64{8'(i), 8'(n), 16'hC35A}};
        sb[i] = tbl[n].zstrb ? '0 : {32{8'(n * 8 + i + 1)}};
      end
      apply(tbl[n].rst, tbl[n].stall, tbl[n].valid, tbl[n].addr, d, sb,
            tbl[n].exp_rdy, tbl[n].src, $sformatf("v%0d", n));
    end

    // Passthrough: pointer is at 4, lone requester 3 lands on port 0 unmodified.
    for (int i = 0; i < NR; i++) begin
      d[i] = {64{32'h1234_5678}};
      sb[i] = {32{8'h55}};
    end
    d[3] = '1;
    sb[3] = SW'(1);
    apply(1'b0, 1'b0, 8'h08, apt, d, sb, 8'h08, 16'hFFF3, "passthru");

`ifdef VRF_ARB_PERF_CNT_EN
    apply(1'b1, 1'b0, 8'h00, a07, d, sb, 8'h00, 16'hFFFF, "perf_rst");
    chk("grant_cnt after reset", grant_cnt, 32'd0);
    chk("conflict_cnt after reset", conflict_cnt, 32'd0);
    apply(1'b0, 1'b0, 8'h07, acf, d, sb, 8'h05, 16'hFF20, "perf_c1");
    apply(1'b0, 1'b0, 8'h02, acf, d, sb, 8'h02, 16'hFFF1, "perf_c2");
    chk("grant_cnt", grant_cnt, 32'd3);
    chk("conflict_cnt", conflict_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
